// File: rtl/console_uart_tx.sv
// Console UART transmitter: processor stores are queued in a FIFO and sent as 8N1 frames.
// Frames leave back to back while the queue is non-empty; writes into a full queue set OVERRUN.
module console_uart_tx #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CONSOLE_WE,
  input  logic [7:0]                    CONSOLE_WDATA,
  input  logic                          OVR_CLR,
  output logic                          TX,
  output logic                          TX_BUSY,
  output logic                          TX_FULL,
  output logic                          TX_EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   TX_COUNT,
  output logic                          OVERRUN
);

  localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);

  generate
    if (DIV < 2) begin : g_div_check
      $error("console_uart_tx: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("console_uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   baud_cnt, baud_cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            tx_q, tx_nxt;
  logic            overrun_q;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic            fifo_empty, fifo_full, bit_done;
  logic            pop, push, drop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign bit_done   = (baud_cnt == CW'(DIV - 1));

  // A pop on the same edge frees a slot, so a write into a full queue is still taken.
  assign push = CONSOLE_WE && (!fifo_full || pop);
  assign drop = CONSOLE_WE && fifo_full && !pop;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= CONSOLE_WDATA;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overrun_q <= 1'b1;
      else if (OVR_CLR) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      tx_q     <= tx_nxt;
    end
  end

  // shreg[0] always holds the data bit currently on the line (or the next one during START).
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + 1'b1;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    tx_nxt       = tx_q;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        tx_nxt       = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          tx_nxt       = shreg[0];
          state_nxt    = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            tx_nxt      = shreg[1];
            shreg_nxt   = {1'b0, shreg[7:1]};
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_nxt = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shreg_nxt = mem[rd_ptr];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        baud_cnt_nxt = '0;
        tx_nxt       = 1'b1;
        state_nxt    = IDLE;
      end
    endcase
  end

  assign TX       = tx_q;
  assign TX_BUSY  = (state != IDLE);
  assign TX_FULL  = fifo_full;
  assign TX_EMPTY = fifo_empty;
  assign TX_COUNT = count;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx at DIV=4: accepted bytes go into a scoreboard queue and a
// line monitor checks every cycle of every frame against the byte popped from that queue.
module tb_console_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 16;

  logic       CLK, RESET, CONSOLE_WE, OVR_CLR;
  logic [7:0] CONSOLE_WDATA;
  logic       TX, TX_BUSY, TX_FULL, TX_EMPTY, OVERRUN;
  logic [4:0] TX_COUNT;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  bit         rx_active = 0;

  console_uart_tx #(
    .CLOCK_FREQUENCY(40),
    .BAUD_RATE      (10),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CONSOLE_WE   (CONSOLE_WE),
    .CONSOLE_WDATA(CONSOLE_WDATA),
    .OVR_CLR      (OVR_CLR),
    .TX           (TX),
    .TX_BUSY      (TX_BUSY),
    .TX_FULL      (TX_FULL),
    .TX_EMPTY     (TX_EMPTY),
    .TX_COUNT     (TX_COUNT),
    .OVERRUN      (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Line monitor: a falling edge on an idle line starts a frame; each cycle is compared
  // against {stop, data LSB first, start} with every bit exactly DIV cycles long.
  initial begin : rx_monitor
    int         phase;
    bit         checking;
    logic [9:0] frame;
    logic [7:0] cur;
    phase = 0; checking = 0; frame = '1; cur = '0;
    forever begin
      @(negedge CLK);
      if (RESET !== 1'b1) begin
        rx_active = 0;
      end else if (!rx_active) begin
        if (TX === 1'b0) begin
          rx_active = 1;
          phase     = 0;
          if (exp_q.size() == 0) begin
            checking = 0;
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_frame: TX=0 start bit, required idle TX=1");
          end else begin
            cur      = exp_q.pop_front();
            frame    = {1'b1, cur, 1'b0};
            checking = 1;
          end
        end
      end else begin
        phase++;
        if (checking) begin
          vectors++;
          if (TX !== frame[phase/DIV]) begin
            miscompares++;
            $display("[TB] FAIL frame_bit byte=%02h cycle=%0d: TX=%b required %b",
                     cur, phase, TX, frame[phase/DIV]);
          end
        end
        if (phase == 10*DIV - 1) rx_active = 0;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(TX_BUSY === 1'b0 && TX_EMPTY === 1'b1) && n < 3000) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 3000 || exp_q.size() != 0 || rx_active) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: pending=%0d busy=%b rx_active=%0d, required pending=0 busy=0 rx_active=0",
               name, exp_q.size(), TX_BUSY, rx_active);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; CONSOLE_WE = 1'b0; CONSOLE_WDATA = '0; OVR_CLR = 1'b0;
    repeat (3) step();
    vectors++;
    if ({TX, TX_BUSY, TX_FULL, TX_EMPTY, OVERRUN, TX_COUNT} !== {5'b10010, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset_held: tx/busy/full/empty/ovr/count=%b, required 10010_00000",
               {TX, TX_BUSY, TX_FULL, TX_EMPTY, OVERRUN, TX_COUNT});
    end
    RESET = 1'b1;
    repeat (2) step();
    vectors++;
    if ({TX, TX_BUSY, TX_FULL, TX_EMPTY, OVERRUN, TX_COUNT} !== {5'b10010, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset_released: tx/busy/full/empty/ovr/count=%b, required 10010_00000",
               {TX, TX_BUSY, TX_FULL, TX_EMPTY, OVERRUN, TX_COUNT});
    end
  endtask

  task automatic test_single_byte();
    CONSOLE_WE = 1'b1; CONSOLE_WDATA = 8'h48; exp_q.push_back(8'h48);
    step();
    CONSOLE_WE = 1'b0;
    vectors++;
    if ({TX, TX_BUSY, TX_EMPTY, TX_COUNT} !== {3'b100, 5'd1}) begin
      miscompares++;
      $display("[TB] FAIL single_write_edge: tx/busy/empty/count=%b, required 100_00001",
               {TX, TX_BUSY, TX_EMPTY, TX_COUNT});
    end
    step();
    vectors++;
    if ({TX, TX_BUSY, TX_EMPTY, TX_COUNT} !== {3'b011, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL single_pop_edge: tx/busy/empty/count=%b, required 011_00000",
               {TX, TX_BUSY, TX_EMPTY, TX_COUNT});
    end
    repeat (39) step();
    vectors++;
    if ({TX, TX_BUSY} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL single_stop_k40: tx/busy=%b, required 11", {TX, TX_BUSY});
    end
    step();
    vectors++;
    if ({TX, TX_BUSY} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL single_idle_k41: tx/busy=%b, required 10", {TX, TX_BUSY});
    end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    logic eb, ee;
    CONSOLE_WE = 1'b1; CONSOLE_WDATA = 8'h55; exp_q.push_back(8'h55);
    step();
    CONSOLE_WDATA = 8'hAA; exp_q.push_back(8'hAA);
    step();
    CONSOLE_WE = 1'b0;
    for (int i = 1; i <= 81; i++) begin
      if (i > 1) step();
      eb = (i <= 80);
      ee = (i >= 41);
      vectors++;
      if ({TX_BUSY, TX_EMPTY} !== {eb, ee}) begin
        miscompares++;
        $display("[TB] FAIL b2b_edge%0d: busy/empty=%b, required %b", i, {TX_BUSY, TX_EMPTY}, {eb, ee});
      end
    end
    wait_drain("b2b");
  endtask

  task automatic test_overflow();
    CONSOLE_WE = 1'b1;
    for (int b = 1; b <= 18; b++) begin
      CONSOLE_WDATA = 8'(b);
      if (b <= 17) exp_q.push_back(8'(b));
      step();
      if (b == 17) begin
        vectors++;
        if ({TX_COUNT, TX_FULL, OVERRUN} !== {5'd16, 2'b10}) begin
          miscompares++;
          $display("[TB] FAIL ovf_full: count/full/ovr=%b, required 10000_10", {TX_COUNT, TX_FULL, OVERRUN});
        end
      end
    end
    vectors++;
    if ({TX_COUNT, OVERRUN} !== {5'd16, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL ovf_drop: count/ovr=%b, required 10000_1", {TX_COUNT, OVERRUN});
    end
    CONSOLE_WE = 1'b0; OVR_CLR = 1'b1;
    step();
    OVR_CLR = 1'b0;
    vectors++;
    if (OVERRUN !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear: OVERRUN=%b, required 0", OVERRUN);
    end
    CONSOLE_WE = 1'b1; CONSOLE_WDATA = 8'hEE; OVR_CLR = 1'b1;
    step();
    CONSOLE_WE = 1'b0; OVR_CLR = 1'b0;
    vectors++;
    if ({OVERRUN, TX_COUNT} !== {1'b1, 5'd16}) begin
      miscompares++;
      $display("[TB] FAIL ovf_set_wins: ovr/count=%b, required 1_10000", {OVERRUN, TX_COUNT});
    end
    OVR_CLR = 1'b1;
    step();
    OVR_CLR = 1'b0;
    vectors++;
    if (OVERRUN !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear2: OVERRUN=%b, required 0", OVERRUN);
    end
    wait_drain("overflow");
  endtask

  task automatic test_full_pop();
    CONSOLE_WE = 1'b1; CONSOLE_WDATA = 8'hA0; exp_q.push_back(8'hA0);
    step();
    for (int j = 1; j <= 16; j++) begin
      CONSOLE_WDATA = 8'hB0 + 8'(j); exp_q.push_back(8'hB0 + 8'(j));
      step();
    end
    CONSOLE_WE = 1'b0;
    repeat (24) step();
    vectors++;
    if ({TX_COUNT, TX_FULL} !== {5'd16, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL fullpop_before: count/full=%b, required 10000_1", {TX_COUNT, TX_FULL});
    end
    CONSOLE_WE = 1'b1; CONSOLE_WDATA = 8'hC7; exp_q.push_back(8'hC7);
    step();
    CONSOLE_WE = 1'b0;
    vectors++;
    if ({TX_COUNT, OVERRUN, TX} !== {5'd16, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL fullpop_edge: count/ovr/tx=%b, required 10000_00", {TX_COUNT, OVERRUN, TX});
    end
    wait_drain("fullpop");
  endtask

  task automatic test_reset_mid_frame();
    CONSOLE_WE = 1'b1;
    for (int b = 0; b < 6; b++) begin
      CONSOLE_WDATA = 8'h11 * 8'(b); exp_q.push_back(8'h11 * 8'(b));
      step();
    end
    CONSOLE_WE = 1'b0;
    repeat (13) step();
    vectors++;
    if ({TX, TX_BUSY, TX_COUNT} !== {2'b01, 5'd5}) begin
      miscompares++;
      $display("[TB] FAIL midreset_before: tx/busy/count=%b, required 01_00101", {TX, TX_BUSY, TX_COUNT});
    end
    #2;
    RESET = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if ({TX, TX_BUSY, TX_EMPTY, OVERRUN, TX_COUNT} !== {4'b1010, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL midreset_async: tx/busy/empty/ovr/count=%b, required 1010_00000",
               {TX, TX_BUSY, TX_EMPTY, OVERRUN, TX_COUNT});
    end
    repeat (2) step();
    RESET = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      vectors++;
      if ({TX, TX_BUSY} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL midreset_quiet%0d: tx/busy=%b, required 10", i, {TX, TX_BUSY});
      end
    end
    CONSOLE_WE = 1'b1; CONSOLE_WDATA = 8'hC3; exp_q.push_back(8'hC3);
    step();
    CONSOLE_WE = 1'b0;
    wait_drain("midreset");
  endtask

  task automatic test_wrap();
    int max_count;
    int guard;
    max_count = 0;
    for (int b = 0; b < 40; b++) begin
      guard = 0;
      while (TX_COUNT >= 5'd8 && guard < 1000) begin
        step();
        guard++;
      end
      if (guard >= 1000) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL wrap_pace_timeout: count=%0d, required below 8", TX_COUNT);
      end
      CONSOLE_WE = 1'b1; CONSOLE_WDATA = 8'(b); exp_q.push_back(8'(b));
      step();
      CONSOLE_WE = 1'b0;
      if (int'(TX_COUNT) > max_count) max_count = int'(TX_COUNT);
    end
    vectors++;
    if (OVERRUN !== 1'b0 || max_count > 8) begin
      miscompares++;
      $display("[TB] FAIL wrap_status: ovr=%b max_count=%0d, required ovr=0 max_count<=8", OVERRUN, max_count);
    end
    wait_drain("wrap");
  endtask

  initial begin : main
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_wrap();
    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/console_uart_tx.md
# console_uart_tx

Memory-mapped UART transmitter serving the CPU console port (address 0x00000C0C). Bytes written by the processor via a store to the console address are queued in a FIFO and serialised onto `TX` as 8N1 frames at `BAUD_RATE`. It is the outbound counterpart to the console receive path. The wrapper drives `CONSOLE_WE = MemWrite & dec_CONSOLE` and returns the status bits on console-status reads.

## Interface
- `CLOCK_FREQUENCY`, default 50000000: frequency of `CLK` in Hz.
- `BAUD_RATE`, default 115200: serial bit rate.
- `FIFO_DEPTH`, default 16: queue entries. Must be a power of 2 and at least 2.
- `CLK`, input, 1: the single clock. All state changes on the rising edge.
- `RESET`, input, 1: reset, asynchronous and active-low (0 = reset).
- `CONSOLE_WE`, input, 1: byte write strobe, sampled every rising edge.
- `CONSOLE_WDATA`, input, 8: byte to queue (`WriteData[7:0]`).
- `OVR_CLR`, input, 1: clears `OVERRUN`.
- `TX`, output, 1: serial line. Idle high.
- `TX_BUSY`, output, 1: FSM not in IDLE.
- `TX_FULL`, output, 1: FIFO count == `FIFO_DEPTH`.
- `TX_EMPTY`, output, 1: FIFO count == 0.
- `TX_COUNT`, output, log2(`FIFO_DEPTH`)+1: current FIFO occupancy.
- `OVERRUN`, output, 1: sticky flag, set when a write is dropped.

## Operation
- Bit period: DIV = `CLOCK_FREQUENCY`/`BAUD_RATE`, integer-truncated. DIV < 2 is illegal (elaboration check).
- Frame format: start bit 0, then data bits 0..7 LSB first, then one stop bit 1. A frame is 10×DIV cycles.
- FIFO write:
  - Occurs on an edge where `CONSOLE_WE`=1 and not full.
  - Full is judged on the pre-edge count, except that a pop on the same edge makes room. In that case the write is accepted and the count is unchanged.
- Dropped write: a write with FIFO full and no simultaneous pop is discarded. `OVERRUN` is set to 1.
- `OVERRUN` clear:
  - `OVR_CLR`=1 clears `OVERRUN`.
  - If a drop and `OVR_CLR` occur on the same edge, set wins.
- Pointers: read and write pointers wrap modulo `FIFO_DEPTH`.
- FSM states:
  - IDLE: `TX`=1. If the FIFO is non-empty, pop the head into the shift register, `TX`<=0, go to START.
  - START: after DIV cycles, `TX`<=bit0, go to DATA, bit index = 0.
  - DATA: every DIV cycles, shift out the next bit. After bit 7 has lasted DIV cycles, `TX`<=1, go to STOP.
  - STOP: after DIV cycles:
    - if the FIFO is non-empty, pop, `TX`<=0, go to START (no idle gap between frames);
    - otherwise `TX`<=1, go to IDLE.
- Baud counter: counts 0..DIV-1 inside each bit and restarts at every state transition.
- `TX` is a registered output (glitch-free).
- Reset (asserted at any time, including mid-frame):
  - `TX`=1, state IDLE, FIFO pointers and count = 0, `OVERRUN`=0, baud counter = 0.
  - Any partially sent frame is abandoned. Queued bytes are lost.

## Timing
- Reset values: `TX`=1, `TX_BUSY`=0, `TX_FULL`=0, `TX_EMPTY`=1, `TX_COUNT`=0, `OVERRUN`=0.
- Write at edge k into an empty, idle block:
  - `TX_COUNT`=1 after edge k.
  - Pop at edge k+1: `TX` falls, `TX_BUSY`=1, `TX_COUNT`=0.
- Start-bit timing: the start bit begins 1 cycle after the write edge and lasts exactly DIV cycles. Every bit lasts exactly DIV cycles.
- `TX_BUSY` deasserts on the edge where `TX` returns to IDLE, 10×DIV cycles after the start-bit edge when no further byte is queued.
- Back-to-back frames: the stop bit of frame n is followed immediately by the start bit of frame n+1.
- Status outputs are registered/derived from registered count and update on the same edge as the FIFO operation.

## Test plan
- Reset, then single byte:
  - Setup: `CLOCK_FREQUENCY`=40, `BAUD_RATE`=10 (DIV=4). Hold `RESET`=0, then release. Write 0x48 at edge k.
  - Required: `TX` = 0,0,0,0,1,0,0,1,0,1 (start bit, bits 0–7, stop bit), each level for 4 cycles, starting at edge k+1. `TX_BUSY`=0 at edge k+41.
- Back-to-back frames, DIV=4:
  - Stimulus: write 0x55 and 0xAA on consecutive edges.
  - Required: 80 continuous cycles with no idle gap. `TX_EMPTY`=1 from the second pop onward.
- Overflow, `FIFO_DEPTH`=16:
  - Stimulus: write bytes 1..18 on 18 consecutive edges.
  - Required:
    - byte 1 is sent; bytes 2..17 are queued (`TX_COUNT`=16, `TX_FULL`=1);
    - byte 18 is dropped and `OVERRUN`=1;
    - pulse `OVR_CLR` → `OVERRUN`=0;
    - the serial output contains bytes 1..17 in order.
- Write while full with a simultaneous pop:
  - Setup: keep the FIFO at 16 entries and issue a write on the edge where STOP pops.
  - Required: the write is accepted, `TX_COUNT` stays 16, `OVERRUN` stays 0.
- Reset mid-frame:
  - Stimulus: assert `RESET`=0 asynchronously during data bit 3 with 5 bytes queued.
  - Required: `TX`=1 immediately (no clock edge needed), `TX_COUNT`=0, `TX_BUSY`=0. After release, no frame is emitted until a new write.
- Pointer wrap-around:
  - Stimulus: stream 40 bytes (0x00..0x27) with writes paced to keep the FIFO at or below 8 entries.
  - Required: all 40 bytes are received in order, and `OVERRUN` stays 0.
